// File: rtl/sm3_inpt_arb_if.sv
// sm3_inpt_arb_if: one message-input beat channel (data, byte mask, valid, last, ready)
// master drives d/vld_byte/vld/lst and receives rdy; slave is the mirror.
// vld_byte is MSB-first and passed untouched to the pad core.
interface sm3_inpt_arb_if #(
  parameter int INPT_DW = 32,
  parameter int INPT_BYTE_W = INPT_DW / 8
);
  logic [INPT_DW-1:0] d;
  logic [INPT_BYTE_W-1:0] vld_byte;
  logic vld;
  logic lst;
  logic rdy;
  modport master (output d, vld_byte, vld, lst, input rdy);
  modport slave (input d, vld_byte, vld, lst, output rdy);
endinterface

// File: rtl/sm3_inpt_arb.sv
// sm3_inpt_arb: two-requester round-robin sequencer feeding whole messages to sm3_pad_core
// clk, rst_n      : clock, asynchronous active-low reset
// req0, req1      : requester channels (slave side), rdy asserted only for the granted one
// msg             : pad core message input channel (master side), combinational pass-through
// cmprss_done     : digest complete pulse, releases the bus after a message
// arb_gnt_id      : granted requester, meaningful while arb_busy
// arb_busy        : message in transfer or awaiting digest completion
// xfer_beat_cnt   : saturating count of beats accepted in the current message
module sm3_inpt_arb #(
  parameter int INPT_DW = 32,
  parameter int INPT_BYTE_W = INPT_DW / 8,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  sm3_inpt_arb_if.slave req0,
  sm3_inpt_arb_if.slave req1,
  sm3_inpt_arb_if.master msg,
  input  logic cmprss_done,
  output logic arb_gnt_id,
  output logic arb_busy,
  output logic [CNT_W-1:0] xfer_beat_cnt
);
  localparam logic [1:0] IDLE = 2'd0, XFER = 2'd1, WAIT_DONE = 2'd2;
  localparam logic [CNT_W-1:0] ONE = 1;
  logic [1:0] state;
  logic rr_ptr;
  logic xfer;
  logic g_vld;
  logic g_lst;
  logic acc;
  logic [INPT_DW-1:0] g_d;
  logic [INPT_BYTE_W-1:0] g_vb;
  always_comb begin
    xfer = state == XFER;
    g_vld = arb_gnt_id ? req1.vld : req0.vld;
    g_lst = arb_gnt_id ? req1.lst : req0.lst;
    g_d = arb_gnt_id ? req1.d : req0.d;
    g_vb = arb_gnt_id ? req1.vld_byte : req0.vld_byte;
    msg.vld = xfer & g_vld;
    msg.lst = xfer & g_lst;
    msg.d = xfer ? g_d : '0;
    msg.vld_byte = xfer ? g_vb : '0;
    req0.rdy = xfer & ~arb_gnt_id & msg.rdy;
    req1.rdy = xfer & arb_gnt_id & msg.rdy;
    acc = msg.vld & msg.rdy;
    arb_busy = state != IDLE;
  end
  // the grant is taken once in IDLE and held until the digest completes,
  // so a message is never interleaved with the other requester's beats
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= 1'b0;
      arb_gnt_id <= 1'b0;
      xfer_beat_cnt <= '0;
    end else if (state == IDLE) begin
      if (req0.vld | req1.vld) begin
        arb_gnt_id <= (req0.vld & req1.vld) ? rr_ptr : req1.vld;
        state <= XFER;
      end
    end else if (state == XFER) begin
      if (acc) begin
        xfer_beat_cnt <= &xfer_beat_cnt ? xfer_beat_cnt : xfer_beat_cnt + ONE;
        if (g_lst) begin
          state <= WAIT_DONE;
          rr_ptr <= ~arb_gnt_id;
        end
      end
    end else if (state == WAIT_DONE) begin
      if (cmprss_done) begin
        state <= IDLE;
        xfer_beat_cnt <= '0;
      end
    end else begin
      state <= IDLE;
    end
endmodule

// File: doc/sm3_inpt_arb.md
Name: sm3_inpt_arb

Overview:
- Two-requester round-robin arbiter and sequencer in front of the SM3 padding core's message input bus (msg_inpt_d/vld_byte/vld/lst).
- Grants the bus for one whole message, delivered as a burst of beats ending in lst.
- Then blocks all requesters until the compression core signals digest completion, because the core holds one message at a time.
- Sits between the bus-side request sources and sm3_pad_core.

Parameters:
- INPT_DW, 32, message bus width in bits (32 or 64, matching SM3_INPT_DW_32 / SM3_INPT_DW_64).
- INPT_BYTE_W, INPT_DW/8, width of the byte-valid mask.
- CNT_W, 16, width of the beat counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req0_d  in  INPT_DW  requester 0 data.
- req0_vld_byte  in  INPT_BYTE_W  requester 0 byte-valid mask, MSB-first.
- req0_vld  in  1  requester 0 beat valid / bus request.
- req0_lst  in  1  requester 0 last beat of message.
- req0_rdy  out  1  requester 0 beat accepted.
- req1_d, req1_vld_byte, req1_vld, req1_lst, req1_rdy  same as requester 0.
- msg_inpt_d  out  INPT_DW  to pad core.
- msg_inpt_vld_byte  out  INPT_BYTE_W  to pad core.
- msg_inpt_vld  out  1  to pad core.
- msg_inpt_lst  out  1  to pad core.
- msg_inpt_rdy  in  1  pad core can accept a beat.
- cmprss_done  in  1  single-cycle pulse: digest of current message complete.
- arb_gnt_id  out  1  requester owning the bus (valid when arb_busy=1).
- arb_busy  out  1  a message is being transferred or awaiting completion.
- xfer_beat_cnt  out  CNT_W  beats accepted in the current message; saturating.

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, arb_gnt_id=0, arb_busy=0, xfer_beat_cnt=0. Both req*_rdy, msg_inpt_vld and msg_inpt_lst are 0. msg_inpt_d=0, msg_inpt_vld_byte=0.
- FSM states:
  - IDLE: if any reqN_vld, register the grant and go to XFER next cycle. Priority starts at rr_ptr. Single request: that one wins. Both request: the rr_ptr side wins.
  - XFER: outputs are a combinational mux of the granted requester. msg_inpt_vld = granted reqN_vld. reqN_rdy = msg_inpt_rdy for the granted N only; the other rdy is held 0. A beat is accepted when vld&&rdy, and xfer_beat_cnt increments, saturating at all-ones. An accepted beat with lst moves to WAIT_DONE and sets rr_ptr = ~arb_gnt_id.
  - WAIT_DONE: all rdy=0, msg_inpt_vld=0. cmprss_done goes to IDLE and clears xfer_beat_cnt to 0.
- Outputs outside XFER: msg_inpt_d and msg_inpt_vld_byte are driven 0.
- Arbitration latency: 1 cycle from request in IDLE to the first possible acceptance. Data path latency is 0 (pass-through).
- Back-to-back messages: minimum gap is 1 cycle (the IDLE cycle) after cmprss_done.
- arb_busy is 1 in XFER and WAIT_DONE.
- Boundary conditions:
  - Single-beat message (vld&lst on the first beat): XFER → WAIT_DONE after 1 beat; xfer_beat_cnt=1.
  - msg_inpt_rdy low while lst is presented: stay in XFER; the beat is not counted.
  - Granted requester drops vld mid-message: stay in XFER (bubble); the grant is never revoked.
  - cmprss_done in IDLE or XFER: ignored.
  - Request from the other requester during XFER/WAIT_DONE: its rdy stays 0. It is considered at the next IDLE and wins there via rr_ptr.
  - xfer_beat_cnt at all-ones: holds.
  - rst_n asserted mid-message: immediate return to reset values; the partial message is abandoned. The pad core shares rst_n.
  - msg_inpt_vld_byte is passed unmodified. Only the pad core interprets the mask.

Test Plan:
1. Reset, then req0 single beat d=0x61626300, vld_byte=4'b1110, lst=1 ('abc'), msg_inpt_rdy=1. Required: arb_gnt_id=0. msg_inpt_d=0x61626300 one cycle after the request. req0_rdy=1 for exactly 1 cycle. State WAIT_DONE, xfer_beat_cnt=1. cmprss_done pulse gives arb_busy=0 next cycle.
2. req0 and req1 assert vld in the same cycle after reset, each sending 3 beats of 0x01020304. Required: req0 granted first, 3 beats pass with req1_rdy=0 throughout. After cmprss_done, req1 is granted. After the second cmprss_done, simultaneous requests grant req0 again (rr alternation).
3. req1 16-beat message; msg_inpt_rdy toggles 1,0,1,0. Required: exactly 16 handshakes, xfer_beat_cnt=16, no beat duplicated or dropped. The lst beat is held until rdy=1.
4. cmprss_done pulsed during XFER (mid-message). Required: no state change, transfer completes normally, and WAIT_DONE still waits for a fresh pulse.
5. rst_n dropped after beat 2 of a 5-beat req0 message. Required: arb_busy, msg_inpt_vld and req0_rdy go to 0 asynchronously, and xfer_beat_cnt=0. After release, a new request is granted from IDLE with rr_ptr=0.
